// File: rtl/rtc_read_ctrl.sv
// rtc_read_ctrl
//   Read-side bus master for an external RTC on a multiplexed address/data
//   bus with Intel-style strobes. One start request produces one address
//   phase followed by one read phase, and the byte read back is returned
//   with a single-cycle done pulse.
//
//   Phase sequence: IDLE -> ADDR -> GAP -> READ -> RECOVER -> IDLE.
//   A single 4-bit down-counter times every phase. It is loaded with
//   (phase length - 1) on phase entry, and the phase advances when it hits 0.
//
//   Optional feature (macro RTC_RD_DBLSAMPLE_EN):
//     ad_in is sampled on the last two READ edges. If the two samples
//     differ, the transaction is retried once from ADDR. If they still
//     differ, done is raised with err=1. T_RD must be >= 2 in this build.
//     Without the macro, ad_in is sampled once and err is tied to 0.
//
// Parameters
//   T_ADDR, T_GAP, T_RD, T_REC : phase lengths in clock cycles (1..15)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous reset, active-low
//   start     in   read request, sampled only in IDLE
//   addr      in   [7:0] RTC register address, latched when start is accepted
//   busy      out  high from the cycle after acceptance to the last RECOVER cycle
//   done      out  one-cycle pulse; data_out is valid from this cycle on
//   data_out  out  [7:0] last byte read, held until the next done
//   err       out  double-sample mismatch flag, valid with done
//   ad_in     in   [7:0] RTC AD bus, input side
//   ad_out    out  [7:0] RTC AD bus, output side
//   ad_oe     out  1 = drive the AD bus (tristate lives at the top level)
//   cs_n      out  RTC chip select, active-low
//   rd_n      out  RTC read strobe, active-low
//   wr_n      out  RTC write strobe, active-low (address latch only)
//   ad_n      out  0 = address phase, 1 = data
module rtc_read_ctrl #(
    parameter int T_ADDR = 4,
    parameter int T_GAP  = 2,
    parameter int T_RD   = 6,
    parameter int T_REC  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic       err,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n
);

    localparam logic [3:0] LD_ADDR = 4'(T_ADDR - 1);
    localparam logic [3:0] LD_GAP  = 4'(T_GAP - 1);
    localparam logic [3:0] LD_RD   = 4'(T_RD - 1);
    localparam logic [3:0] LD_REC  = 4'(T_REC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP,
        S_READ,
        S_RECOVER
    } state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       done_nx;
    logic [7:0] data_nx;
    logic [7:0] ad_out_nx;

`ifdef RTC_RD_DBLSAMPLE_EN
    logic [7:0] samp, samp_nx;      // first of the two READ samples
    logic       redo, redo_nx;      // mismatch seen: rerun from ADDR after RECOVER
    logic       retried, retried_nx; // current attempt is already the retry
    logic       err_q, err_nx;
`endif

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt - 4'd1;
        done_nx   = 1'b0;
        data_nx   = data_out;
        ad_out_nx = ad_out;
`ifdef RTC_RD_DBLSAMPLE_EN
        samp_nx    = samp;
        redo_nx    = redo;
        retried_nx = retried;
        err_nx     = err_q;
`endif
        case (state)
            S_IDLE: begin
                cnt_nx = cnt;
                if (start) begin
                    state_nx  = S_ADDR;
                    cnt_nx    = LD_ADDR;
                    ad_out_nx = addr;
`ifdef RTC_RD_DBLSAMPLE_EN
                    redo_nx    = 1'b0;
                    retried_nx = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                if (cnt == 4'd0) begin
                    state_nx = S_GAP;
                    cnt_nx   = LD_GAP;
                end
            end
            S_GAP: begin
                if (cnt == 4'd0) begin
                    state_nx = S_READ;
                    cnt_nx   = LD_RD;
                end
            end
            S_READ: begin
`ifdef RTC_RD_DBLSAMPLE_EN
                if (cnt == 4'd1) begin
                    samp_nx = ad_in;
                end
`endif
                if (cnt == 4'd0) begin
                    state_nx = S_RECOVER;
                    cnt_nx   = LD_REC;
`ifdef RTC_RD_DBLSAMPLE_EN
                    if (ad_in == samp) begin
                        done_nx = 1'b1;
                        data_nx = ad_in;
                        err_nx  = 1'b0;
                    end else if (!retried) begin
                        redo_nx = 1'b1;
                    end else begin
                        done_nx = 1'b1;
                        data_nx = ad_in;
                        err_nx  = 1'b1;
                    end
`else
                    done_nx = 1'b1;
                    data_nx = ad_in;
`endif
                end
            end
            S_RECOVER: begin
                if (cnt == 4'd0) begin
                    state_nx = S_IDLE;
`ifdef RTC_RD_DBLSAMPLE_EN
                    if (redo) begin
                        state_nx   = S_ADDR;
                        cnt_nx     = LD_ADDR;
                        redo_nx    = 1'b0;
                        retried_nx = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Registered strobes are decoded from the next state so they change
    // on the same edge as the state register and never glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= 8'h00;
            ad_out   <= 8'h00;
            ad_oe    <= 1'b0;
            cs_n     <= 1'b1;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            ad_n     <= 1'b1;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            busy     <= (state_nx != S_IDLE);
            done     <= done_nx;
            data_out <= data_nx;
            ad_out   <= ad_out_nx;
            ad_oe    <= (state_nx == S_ADDR);
            cs_n     <= !((state_nx == S_ADDR) || (state_nx == S_READ));
            rd_n     <= !(state_nx == S_READ);
            wr_n     <= !(state_nx == S_ADDR);
            ad_n     <= !(state_nx == S_ADDR);
        end
    end

`ifdef RTC_RD_DBLSAMPLE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            samp    <= 8'h00;
            redo    <= 1'b0;
            retried <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            samp    <= samp_nx;
            redo    <= redo_nx;
            retried <= retried_nx;
            err_q   <= err_nx;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_read_ctrl.sv
// Bench for rtc_read_ctrl. Two instances run side by side: u0 with the
// default timing, u1 with all phases at their minimum. A timeline model
// predicts every output of both instances on every cycle. It derives the
// phase purely from the distance to the acceptance cycle.
module tb_rtc_read_ctrl;

    localparam int TA1 = 1;
    localparam int TG1 = 1;
`ifdef RTC_RD_DBLSAMPLE_EN
    localparam int TR1 = 2;
`else
    localparam int TR1 = 1;
`endif
    localparam int TC1 = 1;

    logic       clk;
    logic       rst_v   [2];
    logic       start_v [2];
    logic [7:0] addr_v  [2];
    logic [7:0] adin_v  [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic [7:0] data_v  [2];
    logic       err_v   [2];
    logic [7:0] adout_v [2];
    logic       oe_v    [2];
    logic       csn_v   [2];
    logic       rdn_v   [2];
    logic       wrn_v   [2];
    logic       adn_v   [2];

    rtc_read_ctrl u0 (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .addr(addr_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .data_out(data_v[0]), .err(err_v[0]),
        .ad_in(adin_v[0]), .ad_out(adout_v[0]), .ad_oe(oe_v[0]),
        .cs_n(csn_v[0]), .rd_n(rdn_v[0]), .wr_n(wrn_v[0]), .ad_n(adn_v[0])
    );

    rtc_read_ctrl #(.T_ADDR(TA1), .T_GAP(TG1), .T_RD(TR1), .T_REC(TC1)) u1 (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .addr(addr_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .data_out(data_v[1]), .err(err_v[1]),
        .ad_in(adin_v[1]), .ad_out(adout_v[1]), .ad_oe(oe_v[1]),
        .cs_n(csn_v[1]), .rd_n(rdn_v[1]), .wr_n(wrn_v[1]), .ad_n(adn_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    // model state, per instance
    int         pa [2], pg [2], pr [2], pc [2];
    int         t0 [2];
    logic [7:0] m_addr [2], m_data [2], m_s1 [2];
    logic       m_err [2], m_done [2], m_redo [2], m_retried [2];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, k, act, exp);
        end
    endtask

    function automatic int dlen(input int i);
        return 1 + pa[i] + pg[i] + pr[i];
    endfunction

    // Advance the model with the inputs applied during cycle k.
    task automatic model_step(input int i);
        int rel, d;
        bit idle;
        d = dlen(i);
        m_done[i] = 1'b0;
        if (!rst_v[i]) begin
            t0[i] = -1; m_data[i] = 8'h00; m_err[i] = 1'b0;
            m_redo[i] = 1'b0; m_retried[i] = 1'b0;
        end else begin
            rel  = (t0[i] >= 0) ? k - t0[i] : 0;
            idle = (t0[i] < 0) || (rel >= d + pc[i]);
            if (idle) begin
                if (start_v[i]) begin
                    t0[i] = k; m_addr[i] = addr_v[i];
                    m_redo[i] = 1'b0; m_retried[i] = 1'b0;
                end
            end else begin
                if (rel == d - 2) m_s1[i] = adin_v[i];
                if (rel == d - 1) begin
`ifdef RTC_RD_DBLSAMPLE_EN
                    if (adin_v[i] != m_s1[i] && !m_retried[i]) begin
                        m_redo[i] = 1'b1;
                    end else begin
                        m_done[i] = 1'b1;
                        m_data[i] = adin_v[i];
                        m_err[i]  = (adin_v[i] != m_s1[i]);
                    end
`else
                    m_done[i] = 1'b1;
                    m_data[i] = adin_v[i];
`endif
                end
                if (rel == d + pc[i] - 1 && m_redo[i]) begin
                    t0[i] = k; m_redo[i] = 1'b0; m_retried[i] = 1'b1;
                end
            end
        end
    endtask

    // Compare every output of instance i against the model for cycle k.
    task automatic chk(input int i);
        int rel, d, ph;
        logic [15:0] exp_v, act_v;
        bit a, r;
        d   = dlen(i);
        rel = (t0[i] >= 0) ? k - t0[i] : -1;
        if (rel >= 1 && rel <= pa[i])                ph = 1;
        else if (rel > pa[i] && rel <= pa[i] + pg[i]) ph = 2;
        else if (rel > pa[i] + pg[i] && rel <= d - 1) ph = 3;
        else if (rel >= d && rel <= d + pc[i] - 1)    ph = 4;
        else                                          ph = 0;
        a = (ph == 1);
        r = (ph == 3);
        exp_v = {ph != 0, m_done[i], m_err[i], !(a || r), !r, !a, !a, a, m_data[i]};
        act_v = {busy_v[i], done_v[i], err_v[i], csn_v[i], rdn_v[i], wrn_v[i],
                 adn_v[i], oe_v[i], data_v[i]};
        cmp($sformatf("outputs_u%0d", i), 32'(act_v), 32'(exp_v));
        cmp($sformatf("protocol_u%0d", i),
            {30'd0, !(rdn_v[i] == 1'b0 && wrn_v[i] == 1'b0), !(oe_v[i] && rdn_v[i] == 1'b0)},
            32'd3);
        if (a) cmp($sformatf("ad_out_u%0d", i), 32'(adout_v[i]), 32'(m_addr[i]));
    endtask

    task automatic cycle();
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clk);
        k++;
        #1;
        for (int i = 0; i < 2; i++) chk(i);
    endtask

    typedef struct {
        int         inst;
        logic [7:0] addr;
        logic [7:0] rtc;
        int         lat;
        int         oe_cyc;
        int         rd_cyc;
        int         idle_at;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int n, n_oe, n_rd, ndone;
        bit got;

        vecs[0] = '{0, 8'h21, 8'h59, 13, 4, 6, 17};
        vecs[1] = '{0, 8'hA5, 8'h00, 13, 4, 6, 17};
        vecs[2] = '{0, 8'h5A, 8'hFF, 13, 4, 6, 17};
`ifdef RTC_RD_DBLSAMPLE_EN
        vecs[3] = '{1, 8'h21, 8'h59, 5, 1, 2, 6};
        vecs[4] = '{1, 8'hC3, 8'h3C, 5, 1, 2, 6};
`else
        vecs[3] = '{1, 8'h21, 8'h59, 4, 1, 1, 5};
        vecs[4] = '{1, 8'hC3, 8'h3C, 4, 1, 1, 5};
`endif

        pa[0] = 4;   pg[0] = 2;   pr[0] = 6;   pc[0] = 4;
        pa[1] = TA1; pg[1] = TG1; pr[1] = TR1; pc[1] = TC1;
        for (int i = 0; i < 2; i++) begin
            t0[i] = -1; m_addr[i] = 8'h00; m_data[i] = 8'h00; m_s1[i] = 8'h00;
            m_err[i] = 1'b0; m_done[i] = 1'b0; m_redo[i] = 1'b0; m_retried[i] = 1'b0;
            rst_v[i] = 1'b0; start_v[i] = 1'b1; addr_v[i] = 8'h77; adin_v[i] = 8'h11;
        end

        // reset held with start high
        repeat (3) cycle();
        cmp("reset_data", 32'(data_v[0]), 32'h00);
        cmp("reset_busy", 32'(busy_v[0]), 32'h0);
        for (int i = 0; i < 2; i++) begin rst_v[i] = 1'b1; start_v[i] = 1'b0; end
        cycle();

        // table-driven single transactions
        for (int v = 0; v < 5; v++) begin
            int i;
            i = vecs[v].inst;
            addr_v[i] = vecs[v].addr;
            adin_v[i] = vecs[v].rtc;
            start_v[i] = 1'b1;
            cycle();
            start_v[i] = 1'b0;
            n = 1; n_oe = 0; n_rd = 0; got = 0;
            while (busy_v[i] && n < 80) begin
                if (oe_v[i]) n_oe++;
                if (!rdn_v[i]) n_rd++;
                if (done_v[i]) begin
                    got = 1;
                    cmp("vec_latency", 32'(n), 32'(vecs[v].lat));
                    cmp("vec_data", 32'(data_v[i]), 32'(vecs[v].rtc));
                end
                cycle();
                n++;
            end
            cmp("vec_done_seen", 32'(got), 32'd1);
            cmp("vec_oe_cycles", 32'(n_oe), 32'(vecs[v].oe_cyc));
            cmp("vec_rd_cycles", 32'(n_rd), 32'(vecs[v].rd_cyc));
            cmp("vec_idle_at", 32'(n), 32'(vecs[v].idle_at));
            cycle();
        end

        // start pulses during a transaction are ignored
        adin_v[0] = 8'h42;
        addr_v[0] = 8'h0E;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            start_v[0] = (c == 0 || c == 3 || c == 10);
            cycle();
            if (done_v[0]) ndone++;
        end
        cmp("ignored_starts_done_count", 32'(ndone), 32'd1);

        // start held high: back-to-back transactions
        start_v[0] = 1'b1;
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (done_v[0]) ndone++;
        end
        cmp("held_start_done_count", 32'(ndone), 32'd3);
        start_v[0] = 1'b0;
        repeat (20) cycle();

        // reset in the third READ cycle
        adin_v[0] = 8'h99;
        addr_v[0] = 8'h33;
        start_v[0] = 1'b1;
        cycle();
        start_v[0] = 1'b0;
        repeat (8) cycle();
        cmp("mid_read_rd_low", 32'(rdn_v[0]), 32'h0);
        rst_v[0] = 1'b0;
        cycle();
        rst_v[0] = 1'b1;
        cmp("mid_read_rd_n", 32'(rdn_v[0]), 32'h1);
        cmp("mid_read_cs_n", 32'(csn_v[0]), 32'h1);
        cmp("mid_read_data", 32'(data_v[0]), 32'h00);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (done_v[0]) ndone++;
        end
        cmp("mid_read_no_done", 32'(ndone), 32'd0);
        adin_v[0] = 8'h6B;
        start_v[0] = 1'b1;
        cycle();
        start_v[0] = 1'b0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (done_v[0]) got = 1;
        end
        cmp("after_reset_done", 32'(got), 32'd1);
        cmp("after_reset_data", 32'(data_v[0]), 32'h6B);

`ifdef RTC_RD_DBLSAMPLE_EN
        // ad_in changes on the last READ cycle of both attempts
        addr_v[0] = 8'h10;
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            start_v[0] = (c == 0);
            adin_v[0] = (t0[0] >= 0 && k - t0[0] == dlen(0) - 1) ? 8'h3D : 8'h3C;
            cycle();
            if (done_v[0]) begin
                ndone++;
                cmp("dbl_err_set", 32'(err_v[0]), 32'h1);
                cmp("dbl_data_later", 32'(data_v[0]), 32'h3D);
            end
        end
        cmp("dbl_one_done", 32'(ndone), 32'd1);
        adin_v[0] = 8'h3C;
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            start_v[0] = (c == 0);
            cycle();
            if (done_v[0]) begin
                ndone++;
                cmp("dbl_stable_err", 32'(err_v[0]), 32'h0);
            end
        end
        cmp("dbl_stable_done", 32'(ndone), 32'd1);
`endif

        // randomized traffic on both instances, model checks every cycle
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                start_v[i] = ($urandom_range(0, 3) == 0);
                addr_v[i]  = 8'($urandom);
                adin_v[i]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : adin_v[i];
                rst_v[i]   = ($urandom_range(0, 99) != 0);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
